dcache_req_arbiter: RTL and testbench

- Shares one std_cache_subsystem dcache request port among NR_PORTS core-side requesters (e.g. PTW, load unit, store unit).
- Uses round-robin arbitration and locks the winner through the late-tag phase.
- Tracks outstanding requests in an in-order ID FIFO so that each cache data_rvalid is steered back to the requester that issued it.
- Sits between the requesters' dcache_req_i_t/dcache_req_o_t fields and one cache port.

---
 rtl/dcache_req_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_dcache_req_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_req_arbiter.sv
// rtl/dcache_req_arbiter.sv - round-robin arbiter sharing one dcache request port
// Locks the winner through grant and late-tag phases; an in-order ID FIFO routes responses.
module dcache_req_arbiter #(
    parameter int NR_PORTS = 3,
    parameter int IDX_W    = 12,
    parameter int TAG_W    = 44,
    parameter int DATA_W   = 64,
    parameter int MAX_OUT  = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NR_PORTS-1:0]        req_i,
    input  logic [NR_PORTS-1:0]        we_i,
    input  logic [NR_PORTS*IDX_W-1:0]  index_i,
    input  logic [NR_PORTS*TAG_W-1:0]  tag_i,
    input  logic [NR_PORTS*DATA_W-1:0] wdata_i,
    input  logic [NR_PORTS*DATA_W/8-1:0] be_i,
    input  logic [NR_PORTS*2-1:0]      size_i,
    input  logic [NR_PORTS-1:0]        tag_valid_i,
    input  logic [NR_PORTS-1:0]        kill_i,
    output logic [NR_PORTS-1:0]        gnt_o,
    output logic [NR_PORTS-1:0]        rvalid_o,
    output logic [DATA_W-1:0]          rdata_o,
    output logic                       cache_req_o,
    output logic                       cache_we_o,
    output logic [IDX_W-1:0]           cache_index_o,
    output logic [TAG_W-1:0]           cache_tag_o,
    output logic [DATA_W-1:0]          cache_wdata_o,
    output logic [DATA_W/8-1:0]        cache_be_o,
    output logic [1:0]                 cache_size_o,
    output logic                       cache_tag_valid_o,
    output logic                       cache_kill_o,
    input  logic                       cache_gnt_i,
    input  logic                       cache_rvalid_i,
    input  logic [DATA_W-1:0]          cache_rdata_i,
    output logic                       busy_o,
    output logic                       proto_err_o
);
    localparam int PW = $clog2(NR_PORTS);
    localparam int AW = $clog2(MAX_OUT);
    localparam int BW = DATA_W / 8;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WAIT_GNT = 2'd1;
    localparam logic [1:0] S_TAG      = 2'd2;

    logic [1:0]    state;
    logic [PW-1:0] rr;
    logic [PW-1:0] lat;
    logic [PW-1:0] id_q [MAX_OUT];
    logic          killed_q [MAX_OUT];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic          full;
    logic          arb_valid;
    logic [PW-1:0] arb_win;
    int            best_d;
    logic [PW-1:0] sel;
    logic          sel_vld;
    logic          grant;
    logic          push;
    logic          pop;
    logic          kill_mark;
    logic          head_killed;

    assign full = (count == (AW+1)'(MAX_OUT));

    // Distance from the port after rr decides priority; the nearest requester wins.
    always_comb begin
        best_d    = NR_PORTS;
        arb_win   = '0;
        arb_valid = |req_i;
        for (int p = 0; p < NR_PORTS; p++) begin
            if (req_i[p] && ((p + 2 * NR_PORTS - int'(rr) - 1) % NR_PORTS) < best_d) begin
                best_d  = (p + 2 * NR_PORTS - int'(rr) - 1) % NR_PORTS;
                arb_win = PW'(p);
            end
        end
    end

    always_comb begin
        sel         = '0;
        sel_vld     = 1'b0;
        cache_req_o = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!full && arb_valid) begin
                    sel         = arb_win;
                    sel_vld     = 1'b1;
                    cache_req_o = 1'b1;
                end
            end
            S_WAIT_GNT: begin
                sel         = lat;
                sel_vld     = 1'b1;
                cache_req_o = req_i[lat];
            end
            S_TAG: begin
                sel     = lat;
                sel_vld = 1'b1;
            end
            default: ;
        endcase
        if (rst_i) begin
            sel_vld     = 1'b0;
            cache_req_o = 1'b0;
        end
    end

    always_comb begin
        cache_we_o        = 1'b0;
        cache_index_o     = '0;
        cache_tag_o       = '0;
        cache_wdata_o     = '0;
        cache_be_o        = '0;
        cache_size_o      = '0;
        cache_tag_valid_o = 1'b0;
        cache_kill_o      = 1'b0;
        if (sel_vld) begin
            for (int p = 0; p < NR_PORTS; p++) begin
                if (sel == PW'(p)) begin
                    cache_we_o        = we_i[p];
                    cache_index_o     = index_i[p*IDX_W +: IDX_W];
                    cache_tag_o       = tag_i[p*TAG_W +: TAG_W];
                    cache_wdata_o     = wdata_i[p*DATA_W +: DATA_W];
                    cache_be_o        = be_i[p*BW +: BW];
                    cache_size_o      = size_i[p*2 +: 2];
                    cache_tag_valid_o = tag_valid_i[p];
                    cache_kill_o      = kill_i[p];
                end
            end
        end
    end

    assign grant     = cache_req_o & cache_gnt_i;
    assign push      = grant;
    assign pop       = cache_rvalid_i && (count != '0);
    assign kill_mark = (state == S_TAG) && cache_kill_o;
    // A kill landing on the entry being popped must still suppress its response.
    assign head_killed = killed_q[rd_ptr] | (kill_mark && (rd_ptr == (wr_ptr - 1'b1)));

    always_comb begin
        gnt_o    = '0;
        rvalid_o = '0;
        for (int p = 0; p < NR_PORTS; p++) begin
            gnt_o[p]    = grant && (sel == PW'(p));
            rvalid_o[p] = pop && !head_killed && (id_q[rd_ptr] == PW'(p));
        end
    end

    assign rdata_o = cache_rdata_i;
    assign busy_o  = (state != S_IDLE) || (count != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            rr          <= '0;
            lat         <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            proto_err_o <= 1'b0;
            for (int i = 0; i < MAX_OUT; i++) begin
                id_q[i]     <= '0;
                killed_q[i] <= 1'b0;
            end
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (grant) begin
                        rr    <= sel;
                        lat   <= sel;
                        state <= cache_we_o ? S_IDLE : S_TAG;
                    end else if (cache_req_o) begin
                        lat   <= sel;
                        state <= S_WAIT_GNT;
                    end
                end
                S_WAIT_GNT: begin
                    if (!req_i[lat]) begin
                        state <= S_IDLE;
                    end else if (grant) begin
                        rr    <= lat;
                        state <= cache_we_o ? S_IDLE : S_TAG;
                    end
                end
                S_TAG: begin
                    if (cache_kill_o || cache_tag_valid_o) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (push) begin
                id_q[wr_ptr]     <= sel;
                killed_q[wr_ptr] <= 1'b0;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (kill_mark) begin
                killed_q[wr_ptr - 1'b1] <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (cache_rvalid_i && (count == '0)) begin
                proto_err_o <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dcache_req_arbiter.sv
// tb/tb_dcache_req_arbiter.sv - self-checking bench for dcache_req_arbiter
// Scenario tasks plus a randomized round-robin run against a queue-based reference model.
module tb_dcache_req_arbiter;
    localparam int N  = 3;
    localparam int IW = 12;
    localparam int TW = 44;
    localparam int DW = 64;
    localparam int BW = DW / 8;
    localparam int MO = 4;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0] req_i, we_i, tag_valid_i, kill_i;
    logic [N*IW-1:0] index_i;
    logic [N*TW-1:0] tag_i;
    logic [N*DW-1:0] wdata_i;
    logic [N*BW-1:0] be_i;
    logic [N*2-1:0] size_i;
    logic [N-1:0] gnt_o, rvalid_o;
    logic [DW-1:0] rdata_o;
    logic cache_req_o, cache_we_o, cache_tag_valid_o, cache_kill_o;
    logic [IW-1:0] cache_index_o;
    logic [TW-1:0] cache_tag_o;
    logic [DW-1:0] cache_wdata_o;
    logic [BW-1:0] cache_be_o;
    logic [1:0] cache_size_o;
    logic cache_gnt_i, cache_rvalid_i;
    logic [DW-1:0] cache_rdata_i;
    logic busy_o, proto_err_o;

    int checks = 0;
    int errors = 0;
    int model_rr;
    int exp_q[$];
    logic [IW-1:0] idx_v [N];
    logic [TW-1:0] tag_v [N];
    logic [DW-1:0] wd_v [N];

    always #5 clk = ~clk;

    dcache_req_arbiter #(.NR_PORTS(N), .IDX_W(IW), .TAG_W(TW), .DATA_W(DW), .MAX_OUT(MO)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req_i), .we_i(we_i), .index_i(index_i), .tag_i(tag_i),
        .wdata_i(wdata_i), .be_i(be_i), .size_i(size_i), .tag_valid_i(tag_valid_i), .kill_i(kill_i),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .cache_req_o(cache_req_o),
        .cache_we_o(cache_we_o), .cache_index_o(cache_index_o), .cache_tag_o(cache_tag_o),
        .cache_wdata_o(cache_wdata_o), .cache_be_o(cache_be_o), .cache_size_o(cache_size_o),
        .cache_tag_valid_o(cache_tag_valid_o), .cache_kill_o(cache_kill_o),
        .cache_gnt_i(cache_gnt_i), .cache_rvalid_i(cache_rvalid_i), .cache_rdata_i(cache_rdata_i),
        .busy_o(busy_o), .proto_err_o(proto_err_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_fields();
        for (int p = 0; p < N; p++) begin
            idx_v[p] = IW'($urandom());
            tag_v[p] = TW'({$urandom(), $urandom()});
            wd_v[p]  = {$urandom(), $urandom()};
            index_i[p*IW +: IW] = idx_v[p];
            tag_i[p*TW +: TW]   = tag_v[p];
            wdata_i[p*DW +: DW] = wd_v[p];
            be_i[p*BW +: BW]    = BW'($urandom());
            size_i[p*2 +: 2]    = 2'($urandom());
        end
    endtask

    task automatic clear_inputs();
        req_i = '0; we_i = '0; tag_valid_i = '0; kill_i = '0;
        cache_gnt_i = 1'b0; cache_rvalid_i = 1'b0; cache_rdata_i = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_rr = 0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        clear_inputs();
        rand_fields();
        rst = 1'b1;
        req_i = 3'b111; cache_gnt_i = 1'b1;
        #2;
        checks++; if (cache_req_o !== 1'b0) begin errors++; $display("FAIL reset_cache_req got %b want 0", cache_req_o); end
        checks++; if (gnt_o !== 3'b000) begin errors++; $display("FAIL reset_gnt got %b want 000", gnt_o); end
        checks++; if (cache_index_o !== '0) begin errors++; $display("FAIL reset_index got %h want 0", cache_index_o); end
        checks++; if ({busy_o, proto_err_o, rvalid_o} !== 5'b0) begin errors++; $display("FAIL reset_status got %b want 0", {busy_o, proto_err_o, rvalid_o}); end
        do_reset();
    endtask

    task automatic test_single_load();
        do_reset();
        rand_fields();
        req_i = 3'b010;
        #2;
        checks++; if (cache_req_o !== 1'b1 || cache_index_o !== idx_v[1]) begin errors++; $display("FAIL load_req got req=%b idx=%h want 1 %h", cache_req_o, cache_index_o, idx_v[1]); end
        checks++; if (gnt_o !== 3'b000) begin errors++; $display("FAIL load_nognt got %b want 000", gnt_o); end
        tick();
        cache_gnt_i = 1'b1;
        #2;
        checks++; if (gnt_o !== 3'b010) begin errors++; $display("FAIL load_gnt got %b want 010", gnt_o); end
        tick();
        req_i = '0; cache_gnt_i = 1'b0; tag_valid_i = 3'b010;
        #2;
        checks++; if (cache_req_o !== 1'b0 || cache_tag_o !== tag_v[1] || cache_tag_valid_o !== 1'b1) begin
            errors++; $display("FAIL load_tag got req=%b tag=%h tv=%b want 0 %h 1", cache_req_o, cache_tag_o, cache_tag_valid_o, tag_v[1]); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL load_busy got %b want 1", busy_o); end
        tick();
        tag_valid_i = '0;
        tick();
        tick();
        cache_rvalid_i = 1'b1; cache_rdata_i = 64'hDEAD_BEEF;
        #2;
        checks++; if (rvalid_o !== 3'b010 || rdata_o !== 64'hDEAD_BEEF) begin errors++; $display("FAIL load_resp got %b %h want 010 deadbeef", rvalid_o, rdata_o); end
        tick();
        cache_rvalid_i = 1'b0;
        #2;
        checks++; if (busy_o !== 1'b0 || gnt_o !== 3'b000) begin errors++; $display("FAIL load_idle got busy=%b gnt=%b want 0 000", busy_o, gnt_o); end
    endtask

    // Reference: nearest requester after the last granted port; responses return in grant order.
    task automatic rr_cycle(input logic [N-1:0] r, output int winner);
        logic [N-1:0] eg, ev;
        logic         rv;
        winner = -1;
        rand_fields();
        req_i = r; we_i = '1; cache_gnt_i = 1'b1;
        rv = (exp_q.size() > 0);
        cache_rvalid_i = rv;
        cache_rdata_i = {$urandom(), $urandom()};
        if (exp_q.size() < MO) begin
            for (int k = N; k >= 1; k--) begin
                if (r[(model_rr + k) % N]) winner = (model_rr + k) % N;
            end
        end
        eg = (winner >= 0) ? N'(1 << winner) : '0;
        ev = rv ? N'(1 << exp_q[0]) : '0;
        #2;
        checks++; if (gnt_o !== eg) begin errors++; $display("FAIL rr_gnt req=%b got %b want %b", r, gnt_o, eg); end
        checks++; if (rvalid_o !== ev || rdata_o !== cache_rdata_i) begin errors++; $display("FAIL rr_rvalid got %b want %b", rvalid_o, ev); end
        if (winner >= 0) begin
            checks++; if (cache_index_o !== idx_v[winner] || cache_wdata_o !== wd_v[winner]) begin
                errors++; $display("FAIL rr_mux got %h %h want %h %h", cache_index_o, cache_wdata_o, idx_v[winner], wd_v[winner]); end
        end
        if (rv) void'(exp_q.pop_front());
        if (winner >= 0) begin
            exp_q.push_back(winner);
            model_rr = winner;
        end
        tick();
    endtask

    task automatic test_round_robin();
        int cnt [N];
        int w;
        do_reset();
        for (int p = 0; p < N; p++) cnt[p] = 0;
        for (int c = 0; c < 6; c++) begin
            rr_cycle(3'b111, w);
            if (w >= 0) cnt[w]++;
        end
        for (int p = 0; p < N; p++) begin
            checks++; if (cnt[p] != 2) begin errors++; $display("FAIL rr_share port%0d got %0d want 2", p, cnt[p]); end
        end
        for (int c = 0; c < 40; c++) rr_cycle(N'($urandom_range(0, 7)), w);
        req_i = '0; cache_gnt_i = 1'b0; cache_rvalid_i = 1'b0;
        while (exp_q.size() > 0) rr_cycle('0, w);
        cache_rvalid_i = 1'b0;
        #2;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rr_drain busy got %b want 0", busy_o); end
    endtask

    task automatic test_stall_lock();
        logic [N-1:0] ids [3];
        ids[0] = 3'b100; ids[1] = 3'b001; ids[2] = 3'b100;
        do_reset();
        rand_fields();
        we_i = '1; req_i = 3'b100; cache_gnt_i = 1'b1;
        #2;
        checks++; if (gnt_o !== 3'b100) begin errors++; $display("FAIL stall_pre got %b want 100", gnt_o); end
        tick();
        req_i = 3'b101; cache_gnt_i = 1'b0;
        for (int c = 0; c < 6; c++) begin
            cache_gnt_i = (c == 5);
            index_i[2*IW +: IW] = IW'($urandom());
            #2;
            checks++; if (cache_index_o !== idx_v[0] || gnt_o !== ((c == 5) ? 3'b001 : 3'b000)) begin
                errors++; $display("FAIL stall_lock c%0d got idx=%h gnt=%b want %h", c, cache_index_o, gnt_o, idx_v[0]); end
            tick();
        end
        req_i = 3'b100;
        idx_v[2] = index_i[2*IW +: IW];
        #2;
        checks++; if (gnt_o !== 3'b100 || cache_index_o !== idx_v[2]) begin errors++; $display("FAIL stall_next got %b %h want 100 %h", gnt_o, cache_index_o, idx_v[2]); end
        tick();
        req_i = '0; cache_gnt_i = 1'b0; cache_rvalid_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #2;
            checks++; if (rvalid_o !== ids[k]) begin errors++; $display("FAIL stall_resp%0d got %b want %b", k, rvalid_o, ids[k]); end
            tick();
        end
        cache_rvalid_i = 1'b0;
    endtask

    task automatic test_kill();
        do_reset();
        rand_fields();
        req_i = 3'b100; we_i = '0; cache_gnt_i = 1'b1;
        #2;
        checks++; if (gnt_o !== 3'b100) begin errors++; $display("FAIL kill_gnt got %b want 100", gnt_o); end
        tick();
        req_i = '0; cache_gnt_i = 1'b0; kill_i = 3'b100;
        #2;
        checks++; if (cache_kill_o !== 1'b1 || cache_req_o !== 1'b0 || cache_tag_o !== tag_v[2]) begin
            errors++; $display("FAIL kill_tag got kill=%b req=%b tag=%h want 1 0 %h", cache_kill_o, cache_req_o, cache_tag_o, tag_v[2]); end
        tick();
        kill_i = '0; cache_rvalid_i = 1'b1;
        #2;
        checks++; if (rvalid_o !== 3'b000) begin errors++; $display("FAIL kill_resp got %b want 000", rvalid_o); end
        tick();
        cache_rvalid_i = 1'b0;
        #2;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL kill_busy got %b want 0", busy_o); end
        req_i = 3'b010; cache_gnt_i = 1'b1;
        tick();
        req_i = '0; cache_gnt_i = 1'b0; kill_i = 3'b010; tag_valid_i = 3'b010; cache_rvalid_i = 1'b1;
        #2;
        checks++; if (rvalid_o !== 3'b000) begin errors++; $display("FAIL kill_same_cycle got %b want 000", rvalid_o); end
        tick();
        clear_inputs();
        #2;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL kill_same_busy got %b want 0", busy_o); end
    endtask

    task automatic test_fifo_full();
        int ids [4];
        int rsp [4];
        ids[0] = 0; ids[1] = 1; ids[2] = 2; ids[3] = 0;
        rsp[0] = 1; rsp[1] = 2; rsp[2] = 0; rsp[3] = 1;
        do_reset();
        rand_fields();
        we_i = '1; cache_gnt_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_i = N'(1 << ids[k]);
            #2;
            checks++; if (gnt_o !== N'(1 << ids[k])) begin errors++; $display("FAIL full_fill%0d got %b want %b", k, gnt_o, N'(1 << ids[k])); end
            tick();
        end
        req_i = 3'b010;
        #2;
        checks++; if (cache_req_o !== 1'b0 || gnt_o !== 3'b000) begin errors++; $display("FAIL full_block got req=%b gnt=%b want 0 000", cache_req_o, gnt_o); end
        tick();
        cache_rvalid_i = 1'b1;
        #2;
        checks++; if (rvalid_o !== 3'b001 || cache_req_o !== 1'b0) begin errors++; $display("FAIL full_pop got rv=%b req=%b want 001 0", rvalid_o, cache_req_o); end
        tick();
        cache_rvalid_i = 1'b0;
        #2;
        checks++; if (cache_req_o !== 1'b1 || gnt_o !== 3'b010) begin errors++; $display("FAIL full_resume got req=%b gnt=%b want 1 010", cache_req_o, gnt_o); end
        tick();
        req_i = '0; cache_gnt_i = 1'b0; cache_rvalid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #2;
            checks++; if (rvalid_o !== N'(1 << rsp[k])) begin errors++; $display("FAIL full_resp%0d got %b want %b", k, rvalid_o, N'(1 << rsp[k])); end
            tick();
        end
        cache_rvalid_i = 1'b0;
        #2;
        checks++; if (busy_o !== 1'b0 || proto_err_o !== 1'b0) begin errors++; $display("FAIL full_end got busy=%b perr=%b want 0 0", busy_o, proto_err_o); end
    endtask

    task automatic test_protocol_reset();
        do_reset();
        rand_fields();
        cache_rvalid_i = 1'b1;
        #2;
        checks++; if (rvalid_o !== 3'b000) begin errors++; $display("FAIL perr_rvalid got %b want 000", rvalid_o); end
        tick();
        cache_rvalid_i = 1'b0;
        #2;
        checks++; if (proto_err_o !== 1'b1) begin errors++; $display("FAIL perr_set got %b want 1", proto_err_o); end
        tick();
        tick();
        checks++; if (proto_err_o !== 1'b1) begin errors++; $display("FAIL perr_sticky got %b want 1", proto_err_o); end
        we_i = '1; cache_gnt_i = 1'b1; req_i = 3'b001;
        tick();
        req_i = 3'b010;
        tick();
        req_i = '0; cache_gnt_i = 1'b0;
        #2;
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL perr_outstanding got %b want 1", busy_o); end
        rst = 1'b1;
        #2;
        checks++; if (proto_err_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL perr_reset got perr=%b busy=%b want 0 0", proto_err_o, busy_o); end
        tick();
        rst = 1'b0;
        cache_rvalid_i = 1'b1;
        #2;
        checks++; if (rvalid_o !== 3'b000) begin errors++; $display("FAIL perr_stale got %b want 000", rvalid_o); end
        tick();
        cache_rvalid_i = 1'b0;
        #2;
        checks++; if (proto_err_o !== 1'b1) begin errors++; $display("FAIL perr_again got %b want 1", proto_err_o); end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        index_i = '0; tag_i = '0; wdata_i = '0; be_i = '0; size_i = '0;
        test_reset();
        test_single_load();
        test_round_robin();
        test_stall_lock();
        test_kill();
        test_fifo_full();
        test_protocol_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
